flush_sequencer: RTL

Parametrised pipeline-flush and cache-flush sequencer for the Ariane/CVA6 core. It decodes commit-stage flush causes (mispredict, fence, fence.i, sfence.vma, fence.t, CSR/commit flush, exception/eret/debug) into same-cycle pipeline flush pulses. For fences, it drives a registered request/acknowledge handshake to `NrFlushChan` cache/agent flush channels (D$, I$, L2, ...), halting commit until every selected channel has acknowledged. It sits between the commit stage/CSR file and the frontend, issue, execute and cache subsystems.

---
 rtl/ariane_pkg.sv | 31 +++
 rtl/flush_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ariane_pkg
// Description : Shared CVA6 types used by the flush sequencer: the branch
//               resolution record, the flush-sequencer state encoding and the
//               upper bound on the number of flush channels.
// Revision    : 1.0 - initial release
// ============================================================================
package ariane_pkg;

    // Upper bound on the number of cache/agent flush channels.
    localparam int unsigned FLUSH_SEQ_MAX_CHAN = 8;

    // Branch resolution record from the execute stage.
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
    } bp_resolve_t;

    // Flush sequencer states. ABORT is reachable only in the watchdog build.
    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_WAIT  = 2'd1,
        FLUSH_ABORT = 2'd2
    } flush_seq_state_e;

endpackage : ariane_pkg
`default_nettype wire

// File: rtl/flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flush_sequencer
// Description : Decodes commit-stage flush causes into same-cycle pipeline
//               flush pulses and, for fence / fence.i, runs a registered
//               request/acknowledge handshake with NrFlushChan cache flush
//               channels, halting commit until every selected channel acks.
// Optional    : FLUSH_TIMEOUT_EN - adds a watchdog that aborts a WAIT lasting
//               TimeoutCycles cycles and pulses timeout_o for one cycle.
// Ports       : clk_i, rst_ni (async, active-low)
//               resolved_branch_i, fence_i, fence_i_i, fence_t_i, sfence_vma_i,
//               flush_csr_i, flush_commit_i, ex_valid_i, eret_i,
//               set_debug_pc_i, halt_csr_i, flush_ack_i  - flush causes / acks
//               flush_req_o            - registered per-channel flush request
//               set_pc_commit_o, flush_if_o, flush_unissued_instr_o,
//               flush_id_o, flush_ex_o, flush_bp_o, flush_icache_o,
//               flush_tlb_o            - combinational pipeline pulses
//               halt_o, busy_o, timeout_o
// Revision    : 1.0 - initial release
// ============================================================================
module flush_sequencer
    import ariane_pkg::*;
#(
    parameter int unsigned               NrFlushChan   = 2,
    parameter logic [NrFlushChan-1:0]    FenceMask     = 'b01,
    parameter logic [NrFlushChan-1:0]    FenceIMask    = 'b11,
    parameter int unsigned               TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  bp_resolve_t            resolved_branch_i,
    input  logic                   fence_i,
    input  logic                   fence_i_i,
    input  logic [19:0]            fence_t_i,
    input  logic                   sfence_vma_i,
    input  logic                   flush_csr_i,
    input  logic                   flush_commit_i,
    input  logic                   ex_valid_i,
    input  logic                   eret_i,
    input  logic                   set_debug_pc_i,
    input  logic                   halt_csr_i,
    input  logic [NrFlushChan-1:0] flush_ack_i,
    output logic [NrFlushChan-1:0] flush_req_o,
    output logic                   set_pc_commit_o,
    output logic                   flush_if_o,
    output logic                   flush_unissued_instr_o,
    output logic                   flush_id_o,
    output logic                   flush_ex_o,
    output logic                   flush_bp_o,
    output logic                   flush_icache_o,
    output logic                   flush_tlb_o,
    output logic                   halt_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int unsigned c_TMO_W = $clog2(TimeoutCycles + 1);

    flush_seq_state_e       r_state;
    logic [NrFlushChan-1:0] r_pending;
    logic                   r_timeout;
    logic [NrFlushChan-1:0] w_start_mask;
    logic [NrFlushChan-1:0] w_pend_ack;

    // ------------------------------------------------------------------
    // Pipeline flush pulses. Causes are applied lowest priority first so
    // that a later, stronger cause overrides what an earlier one set.
    // ------------------------------------------------------------------
    always_comb begin
        set_pc_commit_o        = 1'b0;
        flush_if_o             = 1'b0;
        flush_unissued_instr_o = 1'b0;
        flush_id_o             = 1'b0;
        flush_ex_o             = 1'b0;
        flush_bp_o             = 1'b0;
        flush_icache_o         = 1'b0;
        flush_tlb_o            = 1'b0;

        if (resolved_branch_i.is_mispredict) begin
            flush_if_o             = 1'b1;
            flush_unissued_instr_o = 1'b1;
        end
        if (fence_i || fence_i_i || sfence_vma_i) begin
            set_pc_commit_o        = 1'b1;
            flush_if_o             = 1'b1;
            flush_unissued_instr_o = 1'b1;
            flush_id_o             = 1'b1;
            flush_ex_o             = 1'b1;
            flush_icache_o         = fence_i_i;
            flush_tlb_o            = sfence_vma_i;
        end
        if (|fence_t_i) begin
            set_pc_commit_o = 1'b1;
        end
        if (flush_csr_i || flush_commit_i) begin
            set_pc_commit_o        = 1'b1;
            flush_if_o             = 1'b1;
            flush_unissued_instr_o = 1'b1;
            flush_id_o             = 1'b1;
            flush_ex_o             = 1'b1;
        end
        // Trap/return/debug redirect the PC through the CSR file, so the
        // commit-stage set_pc must stay quiet here.
        if (ex_valid_i || eret_i || set_debug_pc_i) begin
            set_pc_commit_o        = 1'b0;
            flush_if_o             = 1'b1;
            flush_unissued_instr_o = 1'b1;
            flush_id_o             = 1'b1;
            flush_ex_o             = 1'b1;
            flush_bp_o             = 1'b1;
        end
    end

    assign w_start_mask = (fence_i   ? FenceMask  : '0)
                        | (fence_i_i ? FenceIMask : '0);
    assign w_pend_ack   = r_pending & ~flush_ack_i;

    // ------------------------------------------------------------------
    // Channel handshake FSM. r_pending is non-zero only in WAIT, so it
    // drives flush_req_o directly.
    // ------------------------------------------------------------------
`ifdef FLUSH_TIMEOUT_EN
    logic [c_TMO_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= FLUSH_IDLE;
            r_pending <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                FLUSH_IDLE: begin
                    if (|w_start_mask) begin
                        r_pending <= w_start_mask;
                        r_cnt     <= '0;
                        r_state   <= FLUSH_WAIT;
                    end
                end
                FLUSH_WAIT: begin
                    r_pending <= w_pend_ack;
                    if (w_pend_ack == '0) begin
                        r_state <= FLUSH_IDLE;
                    end else if (r_cnt == c_TMO_W'(TimeoutCycles - 1)) begin
                        // This cycle is the TimeoutCycles-th in WAIT.
                        r_pending <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= FLUSH_ABORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FLUSH_ABORT: begin
                    r_state <= FLUSH_IDLE;
                end
                default: begin
                    r_pending <= '0;
                    r_state   <= FLUSH_IDLE;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= FLUSH_IDLE;
            r_pending <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                FLUSH_IDLE: begin
                    if (|w_start_mask) begin
                        r_pending <= w_start_mask;
                        r_state   <= FLUSH_WAIT;
                    end
                end
                FLUSH_WAIT: begin
                    r_pending <= w_pend_ack;
                    if (w_pend_ack == '0) begin
                        r_state <= FLUSH_IDLE;
                    end
                end
                default: begin
                    r_pending <= '0;
                    r_state   <= FLUSH_IDLE;
                end
            endcase
        end
    end

    // Watchdog sizing and most branch-record fields are unused here.
    logic w_unused;
    assign w_unused = ^{resolved_branch_i, c_TMO_W[0]};
`endif

    assign flush_req_o = r_pending;
    assign busy_o      = (r_state != FLUSH_IDLE);
    assign halt_o      = halt_csr_i | busy_o;
    assign timeout_o   = r_timeout;

endmodule : flush_sequencer
`default_nettype wire
